// File: rtl/fifo_pkg.sv
// Shared helpers for the BRAM FIFO: pointer/count widths, pointer wrap for
// arbitrary depths, and the legality rule for the parameter set.
package fifo_pkg;

  // Address width for a DEPTH-entry memory; never below one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width; must be able to represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment with an explicit wrap, so non-power-of-2 depths work.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // A parameter set is usable only if the thresholds sit inside the buffer
  // and almost-empty lies strictly below almost-full.
  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af_thresh, input int ae_thresh);
    bit ok;
    ok = 1'b1;
    if (data_w < 1)                              ok = 1'b0;
    if (depth < 2)                               ok = 1'b0;
    if (af_thresh < 1 || af_thresh > depth)      ok = 1'b0;
    if (ae_thresh < 0 || ae_thresh > depth - 1)  ok = 1'b0;
    if (ae_thresh >= af_thresh)                  ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bram_fifo_fwft_ram.sv
// Simple dual-port block RAM: synchronous write, synchronous registered read.
// The read register has a synchronous reset so the FIFO output starts at zero.
module ram
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
)
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Storage array: one word written per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  // Read port: fetch a new word on enable, otherwise keep the last one.
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem[i_raddr];
  end

  // Read data register, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/bram_fifo_fwft.sv
// Single-clock BRAM FIFO with arbitrary depth, standard or first-word-fall-
// through read mode, occupancy count, almost flags and error pulses.
// In FWFT mode the RAM read register doubles as the prefetch/output register;
// a valid flag marks whether it holds the current head word.
module bram_fifo_fwft
  import fifo_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 8,
  parameter  int FWFT      = 0,
  parameter  int AF_THRESH = 6,
  parameter  int AE_THRESH = 2,
  localparam int PTR_W     = addr_w(DEPTH),
  localparam int CNT_W     = cnt_w(DEPTH)
)
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_full,
  output logic              o_almost_full,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("bram_fifo_fwft: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [PTR_W-1:0] wrptr_d, wrptr_q;
  logic [PTR_W-1:0] rdptr_d, rdptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic             wr_ok;
  logic             rd_ok;
  logic             full;
  logic             empty;
  logic             ram_re;

  assign full = (count_q == CNT_W'(DEPTH));

  // Accept decisions, pointer advance, occupancy update and error pulses.
  always_comb begin
    wr_ok       = rstn && i_wren && !full;
    rd_ok       = rstn && i_rden && !empty;
    wrptr_d     = wrptr_q;
    rdptr_d     = rdptr_q;
    count_d     = count_q;
    overflow_d  = i_wren && full;
    underflow_d = i_rden && empty;
    if (wr_ok)  wrptr_d = PTR_W'(ptr_next(32'(wrptr_q), DEPTH));
    // The read pointer follows RAM fetches, which in FWFT mode run ahead of pops.
    if (ram_re) rdptr_d = PTR_W'(ptr_next(32'(rdptr_q), DEPTH));
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers; contents are discarded by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrptr_q     <= '0;
      rdptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrptr_q     <= wrptr_d;
      rdptr_q     <= rdptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (FWFT != 0) begin : g_fwft
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] ram_cnt;

    // Prefetch steering: fetch the next RAM word whenever the output slot is
    // free or being popped. ram_cnt comes from the registered count, so a word
    // is never fetched in the same cycle it is written.
    always_comb begin
      ram_cnt = count_q - CNT_W'(valid_q);
      ram_re  = (ram_cnt != '0) && (!valid_q || i_rden);
      valid_d = valid_q;
      if (ram_re)     valid_d = 1'b1;
      else if (rd_ok) valid_d = 1'b0;
    end

    // Output-word valid flag.
    always_ff @(posedge clk) begin
      if (!rstn) valid_q <= 1'b0;
      else       valid_q <= valid_d;
    end

    assign empty = !valid_q;
  end else begin : g_std
    assign empty  = (count_q == '0);
    assign ram_re = rd_ok;
  end

  ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (wr_ok),
    .i_waddr (wrptr_q),
    .i_wdata (i_wrdata),
    .i_re    (ram_re),
    .i_raddr (rdptr_q),
    .o_rdata (o_rddata)
  );

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_count        = count_q;
  assign o_almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign o_almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule
